// File: rtl/inst_prefetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue_pkg
// Brief    : Shared types and constants for the instruction prefetch queue:
//            fetch FSM state encoding, PC increment, default reset PC and
//            the {pc, inst} FIFO entry layout.
// Revision : 1.0 - initial release
// ============================================================================
package inst_prefetch_queue_pkg;

   // Fetch FSM: IDLE = nothing outstanding, REQ = live request,
   // DROP = request outstanding for a stream that has been flushed.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One buffered fetch: the PC the word was fetched from and the word itself.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_prefetch_queue_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue_fetch_fifo
// Brief    : DEPTH x 64-bit synchronous FIFO of {pc, inst} entries with
//            push, pop, clear, full, empty and occupancy count. Pointers
//            carry one wrap bit so full and empty are distinguishable.
//            The head is read straight from storage, so a pushed entry is
//            visible one cycle after the push edge (no bypass).
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue_fetch_fifo
   import inst_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  fifo_entry_t              push_data,
   input  logic                     pop,
   input  logic                     clear,
   output fifo_entry_t              head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   fifo_entry_t   mem [DEPTH];

   // Pointer update; clear wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entry storage; a push at full with a pop overwrites the departing head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !clear) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count     = wr_ptr - rd_ptr;
   assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_prefetch_queue
// Brief    : Instruction-fetch front end. Issues sequential word fetches over
//            a req/ack handshake (one outstanding request), buffers returned
//            words with their PC in a small FIFO, and presents them to the
//            pipeline through valid/ready. A branch redirect flushes the
//            buffer and restarts fetch at the target PC; a request already
//            in flight is completed and its data dropped.
//            Optional macro PREFETCH_PERF_EN adds stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module inst_prefetch_queue
   import inst_prefetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   input  logic                     deq_ready,
   output logic                     deq_valid,
   output logic [31:0]              deq_inst,
   output logic [31:0]              deq_pc,
   output logic [31:0]              deq_pc_next,
   output logic                     imem_req,
   output logic [31:0]              imem_addr,
   input  logic                     imem_ack,
   input  logic [31:0]              imem_rdata,
   output logic [$clog2(DEPTH):0]   count
`ifdef PREFETCH_PERF_EN
   ,
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_flush_cnt
`endif
);

   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

   fetch_state_t  state;
   fetch_state_t  state_nx;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_nx;
   logic [31:0]   drop_addr;

   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   fifo_entry_t   push_data;
   fifo_entry_t   head_data;
   logic [CW:0]   cnt_after;

   // Redirect squashes both the acked word and the pipeline's dequeue.
   assign push      = (state == ST_REQ) && imem_ack && !redirect;
   assign pop       = deq_valid && deq_ready && !redirect;
   assign push_data = {fetch_pc, imem_rdata};
   assign cnt_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};

   inst_prefetch_queue_fetch_fifo #(
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .clear     (redirect),
      .head_data (head_data),
      .full      (full),
      .empty     (empty),
      .count     (count)
   );

   // Next-state and next-PC logic; a new request is only launched when a
   // FIFO slot is guaranteed for its data.
   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      case (state)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_nx = redirect_pc;
            end else if (!full) begin
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               fetch_pc_nx = redirect_pc;
               state_nx    = imem_ack ? ST_REQ : ST_DROP;
            end else if (imem_ack) begin
               fetch_pc_nx = fetch_pc + PC_INCR;
               state_nx    = (cnt_after < DEPTH_W) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DROP: begin
            if (redirect) fetch_pc_nx = redirect_pc;
            if (imem_ack) state_nx    = ST_REQ;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State, fetch PC and the held address of a request being dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         fetch_pc  <= RESET_PC;
         drop_addr <= '0;
      end else begin
         state    <= state_nx;
         fetch_pc <= fetch_pc_nx;
         if ((state == ST_REQ) && redirect && !imem_ack) drop_addr <= fetch_pc;
      end
   end

   assign imem_req    = (state == ST_REQ) || (state == ST_DROP);
   assign imem_addr   = (state == ST_DROP) ? drop_addr : fetch_pc;

   assign deq_valid   = !empty;
   assign deq_pc      = head_data.pc;
   assign deq_inst    = head_data.inst;
   assign deq_pc_next = deq_valid ? (head_data.pc + PC_INCR) : '0;

`ifdef PREFETCH_PERF_EN
   logic flush_hit;
   assign flush_hit = redirect && ((count != '0) || (state == ST_REQ));

   // Saturating stall and flush event counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (deq_ready && !deq_valid && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (flush_hit && (perf_flush_cnt != 32'hFFFF_FFFF))
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
   end
`else
   // Performance counters not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_prefetch_queue
// Brief    : Scoreboard bench for inst_prefetch_queue. Stimulus pushes the
//            hand-derived {pc, inst} stream expected at deq_*; a monitor pops
//            and compares on every accepted dequeue. A second instance with
//            RESET_PC = FFFF_FFF8 covers address wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_prefetch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        deq_ready;
   logic        deq_valid;
   logic [31:0] deq_inst, deq_pc, deq_pc_next;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_rdata;
   logic [2:0]  count;
   logic        ack_always, ack_manual;

   logic        deq2_valid;
   logic [31:0] deq2_inst, deq2_pc, deq2_pc_next;
   logic        imem2_req;
   logic [31:0] imem2_addr, imem2_rdata;
   logic [2:0]  count2;

`ifdef PREFETCH_PERF_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt, perf2_stall_cnt, perf2_flush_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign imem_ack    = imem_req & (ack_always | ack_manual);
   assign imem_rdata  = memf(imem_addr);
   assign imem2_rdata = memf(imem2_addr);

   inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_inst(deq_inst),
      .deq_pc(deq_pc), .deq_pc_next(deq_pc_next), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .count(count)
`ifdef PREFETCH_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk(clk), .rst_n(rst_n), .redirect(1'b0), .redirect_pc(32'h0),
      .deq_ready(1'b1), .deq_valid(deq2_valid), .deq_inst(deq2_inst),
      .deq_pc(deq2_pc), .deq_pc_next(deq2_pc_next), .imem_req(imem2_req),
      .imem_addr(imem2_addr), .imem_ack(imem2_req), .imem_rdata(imem2_rdata),
      .count(count2)
`ifdef PREFETCH_PERF_EN
      , .perf_stall_cnt(perf2_stall_cnt), .perf_flush_cnt(perf2_flush_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      exp_q.delete();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      deq_ready   = 1'b0;
      ack_always  = 1'b1;
      ack_manual  = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic drain(output int cyc);
      deq_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() != 0 && cyc < 40) begin
         step();
         cyc++;
      end
      deq_ready = 1'b0;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d entries left, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic push_seq(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(4*i), memf(base + 32'(4*i))});
   endtask

   // Monitor: every accepted dequeue must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n && deq_valid && deq_ready && !redirect) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_deq: got pc %h, required no entry", deq_pc);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("deq_pc", deq_pc, e[63:32]);
            chk("deq_inst", deq_inst, e[31:0]);
            chk("deq_pc_next", deq_pc_next, e[63:32] + 32'd4);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0;
      do_reset();
      rst_n = 1'b0;
      step();
      // Reset state
      chk("rst_deq_valid", 32'(deq_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0);

      // Sequential fetch with ack tied high, one instruction per cycle
      rst_n = 1'b1;
      step();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_valid_early", 32'(deq_valid), 32'd0);
      step();
      chk("t1_valid", 32'(deq_valid), 32'd1);
      chk("t1_addr1", imem_addr, 32'h4);
      push_seq(32'h0, 8);
      drain(cyc);
      chk("t1_throughput", 32'(cyc), 32'd8);

      // Back-pressure: fill to DEPTH, fetch stops, resumes after release
      repeat (5) step();
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_req_idle", 32'(imem_req), 32'd0);
      chk("t2_valid", 32'(deq_valid), 32'd1);
      push_seq(32'h20, 6);
      drain(cyc);

      // Delayed ack: address held, single enqueue, no duplicate fetch
      do_reset();
      ack_always = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t3_req_hold", 32'(imem_req), 32'd1);
         chk("t3_addr_hold", imem_addr, 32'h0);
         chk("t3_no_enq", 32'(count), 32'd0);
         step();
      end
      ack_manual = 1'b1;
      step();
      ack_manual = 1'b0;
      chk("t3_count", 32'(count), 32'd1);
      chk("t3_next_addr", imem_addr, 32'h4);
      push_seq(32'h0, 1);
      drain(cyc);
      chk("t3_count_after", 32'(count), 32'd0);

      // Redirect with count=3 and an un-acked request pending
      do_reset();
      repeat (4) step();
      ack_always = 1'b0;
      chk("t4_count3", 32'(count), 32'd3);
      chk("t4_addr12", imem_addr, 32'hC);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      chk("t4_flush_count", 32'(count), 32'd0);
      chk("t4_flush_valid", 32'(deq_valid), 32'd0);
      chk("t4_drop_req", 32'(imem_req), 32'd1);
      chk("t4_drop_addr", imem_addr, 32'hC);
      ack_manual = 1'b1;
      step();
      ack_manual = 1'b0;
      chk("t4_drop_discard", 32'(count), 32'd0);
      chk("t4_new_addr", imem_addr, 32'h40);
      ack_always = 1'b1;
      push_seq(32'h40, 2);
      drain(cyc);

      // Redirect in the same cycle as an ack; deq_ready is ignored then
      do_reset();
      repeat (2) step();
      chk("t5_count1", 32'(count), 32'd1);
      chk("t5_addr4", imem_addr, 32'h4);
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      deq_ready   = 1'b1;
      step();
      redirect  = 1'b0;
      deq_ready = 1'b0;
      chk("t5_flush_count", 32'(count), 32'd0);
      chk("t5_new_addr", imem_addr, 32'h80);
      chk("t5_req", 32'(imem_req), 32'd1);
      push_seq(32'h80, 2);
      drain(cyc);

      // Address wrap on the RESET_PC = FFFF_FFF8 instance
      do_reset();
      step();
      chk("t6_addr_f8", imem2_addr, 32'hFFFF_FFF8);
      step();
      chk("t6_addr_fc", imem2_addr, 32'hFFFF_FFFC);
      chk("t6_pc_f8", deq2_pc, 32'hFFFF_FFF8);
      chk("t6_inst_f8", deq2_inst, memf(32'hFFFF_FFF8));
      chk("t6_next_fc", deq2_pc_next, 32'hFFFF_FFFC);
      step();
      chk("t6_addr_wrap", imem2_addr, 32'h0);
      chk("t6_pc_fc", deq2_pc, 32'hFFFF_FFFC);
      chk("t6_next_wrap", deq2_pc_next, 32'h0);
      step();
      chk("t6_pc_0", deq2_pc, 32'h0);
      chk("t6_next_4", deq2_pc_next, 32'h4);
      chk("t6_valid", 32'(deq2_valid), 32'd1);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
Instruction-fetch front end that sits directly upstream of the 5-stage datapath's IF/ID registers.
- Issues sequential word fetches to instruction memory over a req/ack handshake.
- Buffers returned words, each with its PC, in a small FIFO and presents them to the pipeline through a valid/ready interface.
- Discards the buffered stream and restarts fetch at a new PC on a branch redirect from the MEM stage.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  main clock
rst_n  input  1  reset; asynchronous, active-low
redirect  input  1  branch taken in MEM; flush queue and refetch
redirect_pc  input  32  new fetch PC (branch target)
deq_ready  input  1  pipeline accepts head entry (IF stage enable)
deq_valid  output  1  head entry valid
deq_inst  output  32  head instruction word
deq_pc  output  32  PC of head instruction
deq_pc_next  output  32  deq_pc + 4
imem_req  output  1  instruction memory request
imem_addr  output  32  request word address
imem_ack  input  1  request accepted; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async assert, sync release): deq_valid=0, count=0, imem_req=0, fetch_pc=RESET_PC, state=IDLE, FIFO pointers 0, outputs data 0.
- FSM states:
  - IDLE: no request outstanding.
  - REQ: imem_req=1 with imem_addr=fetch_pc.
  - DROP: an already-issued request is pending but belongs to a flushed stream.
- IDLE -> REQ when count + 0 < DEPTH and no redirect this cycle.
- REQ + imem_ack:
  - Enqueue {fetch_pc, imem_rdata}.
  - fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Go to REQ again if count after this cycle's enq/deq < DEPTH, else IDLE.
- At most one outstanding request. imem_req and imem_addr are held stable until imem_ack; a request is never withdrawn.
- Handshake: ack may arrive in the first cycle of req or any later cycle. imem_rdata is sampled only in the ack cycle.
- Latency: word acked at cycle t appears on deq_* at t+1 (registered FIFO, no bypass).
- Dequeue: head is popped on a rising edge when deq_valid && deq_ready. Simultaneous enq and deq at full is legal, because enq is only issued when space is reserved.
- Redirect (highest priority):
  - FIFO cleared (count=0, deq_valid=0 next cycle); fetch_pc <= redirect_pc.
  - If state=REQ and imem_ack=0 that cycle -> DROP: keep req with the old addr; on ack, discard the data and go to REQ at redirect_pc.
  - If imem_ack=1 in the redirect cycle, that word is discarded; next state REQ at redirect_pc.
  - A redirect arriving while in DROP updates the pending PC; stay in DROP.
  - A redirect cycle ignores deq_ready.
- Pointers: log2(DEPTH)+1 bits. full = MSB differ and LSBs equal; empty = equal.
- Minimum redirect-to-deq_valid: redirect at t, req at t+1, ack at t+1, deq_valid at t+2.
- Reset asserted mid-request: state forced to IDLE immediately. The memory side must tolerate the abandoned request.

Optional Feature:
PREFETCH_PERF_EN:
- Defined: adds outputs perf_stall_cnt (32), counting cycles with deq_ready && !deq_valid, and perf_flush_cnt (32), counting redirects that discarded at least one entry or pending word. Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package: fetch FSM state encoding (IDLE/REQ/DROP), PC_INCR=4, default RESET_PC.
- Sub-module fetch_fifo: synchronous DEPTH x 64-bit FIFO ({pc, inst}) with push, pop, clear, full, empty and count. The FSM and PC logic live in the top block.

Test Plan:
- Reset release, imem_ack tied 1 -> fetch addrs 0,4,8,...; deq_pc=0 / deq_inst=mem[0] valid 2 cycles after release; deq_ready=1 gives one instruction per cycle.
- deq_ready=0, ack always 1 -> exactly DEPTH=4 acks; count=4; imem_req=0; releasing deq_ready restarts fetch next cycle.
- imem_ack delayed 3 cycles -> imem_addr stable for all 3 cycles; one enqueue; no duplicate fetch.
- redirect to 32'h40 while count=3 and REQ pending without ack -> count=0; old-addr ack data dropped; next imem_addr=32'h40; deq_pc=32'h40 first valid.
- redirect in the same cycle as imem_ack -> acked word absent from FIFO; fetch resumes at redirect_pc.
- RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; deq_pc_next wraps to 0 correctly.
